os_drain_collector: RTL and testbench

//  Sits directly below the last PE row of one output-stationary column. It captures
//  the drained accumulator words (PE out_data qualified by out_stagevalid) during a

---
 rtl/os_drain_collector_if.sv | 33 +++
 rtl/os_drain_collector.sv | 200 ++++++++++++++++++++
 tb/tb_os_drain_collector.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/os_drain_collector_if.sv
// Result stream between the drain collector and the result writer.
// The collector is the master (drives the head word and res_valid) and the
// writer is the slave (drives res_ready).
interface os_drain_collector_if #(
  parameter int D_W    = 8,
  parameter int N_ROWS = 4
);

  localparam int ROW_W = $clog2(N_ROWS);

  logic [2*D_W-1:0] res_data;
  logic [ROW_W-1:0] res_row;
  logic             res_last;
  logic             res_valid;
  logic             res_ready;

  modport master (
    output res_data,
    output res_row,
    output res_last,
    output res_valid,
    input  res_ready
  );

  modport slave (
    input  res_data,
    input  res_row,
    input  res_last,
    input  res_valid,
    output res_ready
  );

endinterface

// File: rtl/os_drain_collector.sv
// Drain collector for one output-stationary PE column.
// Captures the accumulator words that fall out of the bottom PE during a drain,
// tags each with its row index (bottom row first), and buffers them in a small
// FIFO so a stalled result writer never back-pressures the array.
// Optional feature: define OS_DRAIN_TIMEOUT_EN to abandon a drain that stays
// idle for TIMEOUT consecutive cycles and raise the sticky timeout_err_o.
module os_drain_collector #(
  parameter int D_W        = 8,
  parameter int N_ROWS     = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  drain_start_i,
  input  logic [2*D_W-1:0]      col_data_i,
  input  logic                  col_valid_i,
  os_drain_collector_if.master  res_if,
  output logic                  busy_o,
  output logic                  overflow_o,
  output logic                  proto_err_o
`ifdef OS_DRAIN_TIMEOUT_EN
  ,
  output logic                  timeout_err_o
`endif
);

  localparam int W     = 2 * D_W;
  localparam int ROW_W = $clog2(N_ROWS);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int PTR_W = AW + 1;

  // Catch illegal parameter combinations at elaboration time.
  if (N_ROWS < 2) begin : g_bad_rows
    $error("os_drain_collector: N_ROWS must be at least 2");
  end
  if ((FIFO_DEPTH < N_ROWS) || ((1 << AW) != FIFO_DEPTH)) begin : g_bad_depth
    $error("os_drain_collector: FIFO_DEPTH must be a power of 2 and >= N_ROWS");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("os_drain_collector: TIMEOUT must be at least 1");
  end

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_e;

  state_e             state_q;
  logic [ROW_W-1:0]   row_cnt_q;
  logic               busy_q;
  logic               proto_err_q;
  logic               overflow_q;

`ifdef OS_DRAIN_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0]   idle_cnt_q;
  logic               timeout_err_q;
`endif

  // FIFO storage: one entry holds the word, its row tag and its last flag.
  logic [W-1:0]       data_mem [FIFO_DEPTH];
  logic [ROW_W-1:0]   row_mem  [FIFO_DEPTH];
  logic               last_mem [FIFO_DEPTH];

  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]      wr_addr, rd_addr;

  logic               fifo_empty;
  logic               fifo_full;
  logic               capture;
  logic               cap_last;
  logic [ROW_W-1:0]   cap_row;
  logic               push;
  logic               pop;
  logic               drop;

  assign wr_addr    = wr_ptr_q[AW-1:0];
  assign rd_addr    = rd_ptr_q[AW-1:0];
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_addr == rd_addr) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

  // A word is captured only while a drain is open; the bottom row drains first,
  // so the first word belongs to row N_ROWS-1.
  assign capture  = (state_q == COLLECT) && col_valid_i;
  assign cap_last = (row_cnt_q == ROW_W'(N_ROWS - 1));
  assign cap_row  = ROW_W'(N_ROWS - 1) - row_cnt_q;

  // A pop frees the head slot in the same cycle, so a full FIFO can still take
  // a word when the consumer is draining it; otherwise the word is lost.
  assign pop  = !fifo_empty && res_if.res_ready;
  assign push = capture && (!fifo_full || pop);
  assign drop = capture && fifo_full && !pop;

  // Head of the FIFO is presented directly from storage (first-word fall-through);
  // it reads as zero whenever nothing is buffered.
  assign res_if.res_valid = !fifo_empty;
  assign res_if.res_data  = fifo_empty ? '0 : data_mem[rd_addr];
  assign res_if.res_row   = fifo_empty ? '0 : row_mem[rd_addr];
  assign res_if.res_last  = fifo_empty ? 1'b0 : last_mem[rd_addr];

  assign busy_o      = busy_q;
  assign overflow_o  = overflow_q;
  assign proto_err_o = proto_err_q;
`ifdef OS_DRAIN_TIMEOUT_EN
  assign timeout_err_o = timeout_err_q;
`endif

  // Drain sequencing: open a drain on drain_start, count captured words, close
  // after the top-row word (or on an idle timeout when that feature is built in).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      row_cnt_q   <= '0;
      busy_q      <= 1'b0;
      proto_err_q <= 1'b0;
`ifdef OS_DRAIN_TIMEOUT_EN
      idle_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (drain_start_i) begin
            state_q   <= COLLECT;
            busy_q    <= 1'b1;
            row_cnt_q <= '0;
`ifdef OS_DRAIN_TIMEOUT_EN
            idle_cnt_q <= '0;
`endif
          end
        end
        COLLECT: begin
          if (drain_start_i) begin
            proto_err_q <= 1'b1;
          end
          if (col_valid_i) begin
`ifdef OS_DRAIN_TIMEOUT_EN
            idle_cnt_q <= '0;
`endif
            if (cap_last) begin
              state_q   <= IDLE;
              busy_q    <= 1'b0;
              row_cnt_q <= '0;
            end else begin
              row_cnt_q <= row_cnt_q + 1'b1;
            end
          end
`ifdef OS_DRAIN_TIMEOUT_EN
          else if (idle_cnt_q == CNT_W'(TIMEOUT - 1)) begin
            state_q       <= IDLE;
            busy_q        <= 1'b0;
            idle_cnt_q    <= '0;
            timeout_err_q <= 1'b1;
          end else begin
            idle_cnt_q <= idle_cnt_q + 1'b1;
          end
`endif
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Pointer arithmetic: each pointer carries one extra wrap bit so that full and
  // empty can be told apart when the addresses coincide.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
  end

  // FIFO pointers and the sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (drop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // FIFO storage write; contents are don't-care until the write pointer covers them.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_addr] <= col_data_i;
      row_mem[wr_addr]  <= cap_row;
      last_mem[wr_addr] <= cap_last;
    end
  end

endmodule

// File: tb/tb_os_drain_collector.sv
// Self-checking bench for os_drain_collector.
// Keeps a queue-based reference of the buffered words and checks every DUT
// output against it once per cycle, on the falling clock edge.
// Define OS_DRAIN_TIMEOUT_EN for both bench and design to exercise the timeout.
module tb_os_drain_collector;

  localparam int D_W        = 8;
  localparam int N_ROWS     = 4;
  localparam int FIFO_DEPTH = 8;
  localparam int TIMEOUT    = 64;
  localparam int W          = 2 * D_W;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         drainStart = 1'b0;
  logic         colValid = 1'b0;
  logic [W-1:0] colData = '0;
  logic         busy;
  logic         overflow;
  logic         protoErr;
`ifdef OS_DRAIN_TIMEOUT_EN
  logic         timeoutErr;
`endif

  os_drain_collector_if #(.D_W(D_W), .N_ROWS(N_ROWS)) resIf ();

  os_drain_collector #(
    .D_W(D_W), .N_ROWS(N_ROWS), .FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .drain_start_i (drainStart),
    .col_data_i    (colData),
    .col_valid_i   (colValid),
    .res_if        (resIf.master),
    .busy_o        (busy),
    .overflow_o    (overflow),
    .proto_err_o   (protoErr)
`ifdef OS_DRAIN_TIMEOUT_EN
    ,
    .timeout_err_o (timeoutErr)
`endif
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] data;
    int           row;
    bit           last;
  } word_t;

  word_t mQ[$];
  bit    mInDrain;
  int    mCount;
  int    mIdle;
  bit    mOverflow;
  bit    mProto;
  bit    mTimeout;

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic modelClear();
    mQ.delete();
    mInDrain  = 1'b0;
    mCount    = 0;
    mIdle     = 0;
    mOverflow = 1'b0;
    mProto    = 1'b0;
    mTimeout  = 1'b0;
  endtask

  // Reference behaviour for one rising edge, from the rules of the block.
  task automatic modelEdge(input bit start, input bit cv, input logic [W-1:0] data, input bit ready);
    bit    wasDrain;
    bit    wasFull;
    bit    popped;
    word_t w;
    wasDrain = mInDrain;
    wasFull  = (mQ.size() == FIFO_DEPTH);
    popped   = (mQ.size() != 0) && ready;
    if (popped) void'(mQ.pop_front());
    if (wasDrain && cv) begin
      w.data = data;
      w.row  = N_ROWS - 1 - mCount;
      w.last = (mCount == N_ROWS - 1);
      if (!wasFull || popped) mQ.push_back(w);
      else mOverflow = 1'b1;
      mCount++;
      mIdle = 0;
      if (w.last) mInDrain = 1'b0;
    end
`ifdef OS_DRAIN_TIMEOUT_EN
    if (wasDrain && !cv) begin
      mIdle++;
      if (mIdle == TIMEOUT) begin
        mInDrain = 1'b0;
        mTimeout = 1'b1;
        mIdle    = 0;
      end
    end
`endif
    if (wasDrain && start) mProto = 1'b1;
    if (!wasDrain && start) begin
      mInDrain = 1'b1;
      mCount   = 0;
      mIdle    = 0;
    end
  endtask

  task automatic checkAll();
    checkOutput("res_valid", resIf.res_valid, (mQ.size() != 0));
    if (mQ.size() != 0) begin
      checkOutput("res_data", resIf.res_data, mQ[0].data);
      checkOutput("res_row", resIf.res_row, mQ[0].row);
      checkOutput("res_last", resIf.res_last, mQ[0].last);
    end
    checkOutput("busy", busy, mInDrain);
    checkOutput("overflow", overflow, mOverflow);
    checkOutput("proto_err", protoErr, mProto);
`ifdef OS_DRAIN_TIMEOUT_EN
    checkOutput("timeout_err", timeoutErr, mTimeout);
`endif
  endtask

  // One clock cycle: check outputs, drive inputs, advance the model at the edge.
  task automatic applyStimulus(input bit start, input bit cv, input logic [W-1:0] data, input bit ready);
    @(negedge clk);
    checkAll();
    drainStart      = start;
    colValid        = cv;
    colData         = data;
    resIf.res_ready = ready;
    @(posedge clk);
    modelEdge(start, cv, data, ready);
  endtask

  // Asynchronous reset assertion with an immediate check, synchronous release.
  task automatic applyReset();
    rst_n = 1'b0;
    modelClear();
    #1;
    checkOutput("rst_valid", resIf.res_valid, 1'b0);
    checkOutput("rst_data", resIf.res_data, '0);
    checkOutput("rst_row", resIf.res_row, '0);
    checkOutput("rst_last", resIf.res_last, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_overflow", overflow, 1'b0);
    checkOutput("rst_proto", protoErr, 1'b0);
    @(negedge clk);
    drainStart = 1'b0;
    colValid   = 1'b0;
    rst_n      = 1'b1;
  endtask

  task automatic drainWords(input int n, input logic [W-1:0] base, input bit ready);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b1, base + W'(i), ready);
  endtask

  initial begin
    resIf.res_ready = 1'b0;
    #2;
    applyReset();

    // Basic drain with a ready consumer.
    applyStimulus(1'b1, 1'b0, '0, 1'b1);
    applyStimulus(1'b0, 1'b1, 16'h0011, 1'b1);
    applyStimulus(1'b0, 1'b1, 16'h0022, 1'b1);
    applyStimulus(1'b0, 1'b1, 16'h0033, 1'b1);
    applyStimulus(1'b0, 1'b1, 16'h0044, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, '0, 1'b1);
    checkOutput("t1_busy_after", busy, 1'b0);

    // Two drains into a stalled consumer fill the FIFO exactly.
    applyStimulus(1'b1, 1'b0, '0, 1'b0);
    drainWords(4, 16'h0100, 1'b0);
    applyStimulus(1'b1, 1'b0, '0, 1'b0);
    drainWords(4, 16'h0200, 1'b0);
    applyStimulus(1'b0, 1'b0, '0, 1'b0);
    checkOutput("t2_full_valid", resIf.res_valid, 1'b1);
    checkOutput("t2_no_overflow", overflow, 1'b0);

    // A third drain on the full FIFO is dropped.
    applyStimulus(1'b1, 1'b0, '0, 1'b0);
    drainWords(4, 16'h0300, 1'b0);
    applyStimulus(1'b0, 1'b0, '0, 1'b0);
    checkOutput("t3_overflow", overflow, 1'b1);
    checkOutput("t3_head_kept", resIf.res_data, 16'h0100);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, '0, 1'b1);

    // Full FIFO with a simultaneous push and pop loses nothing.
    applyReset();
    applyStimulus(1'b1, 1'b0, '0, 1'b0);
    drainWords(4, 16'h0400, 1'b0);
    applyStimulus(1'b1, 1'b0, '0, 1'b0);
    drainWords(4, 16'h0500, 1'b0);
    applyStimulus(1'b1, 1'b0, '0, 1'b0);
    applyStimulus(1'b0, 1'b1, 16'h0600, 1'b1);
    applyStimulus(1'b0, 1'b0, '0, 1'b0);
    checkOutput("t4_no_overflow", overflow, 1'b0);
    checkOutput("t4_head", resIf.res_data, 16'h0401);
    for (int i = 0; i < 12; i++) applyStimulus(1'b0, 1'b0, '0, 1'b1);

    // drain_start while a drain is open is flagged and otherwise ignored.
    applyReset();
    applyStimulus(1'b1, 1'b0, '0, 1'b1);
    drainWords(2, 16'h0700, 1'b1);
    applyStimulus(1'b1, 1'b0, '0, 1'b1);
    drainWords(2, 16'h0702, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, '0, 1'b1);
    checkOutput("t5_proto", protoErr, 1'b1);
    checkOutput("t5_busy", busy, 1'b0);

    // Reset in the middle of a drain, then a fresh drain starts at row 3.
    applyStimulus(1'b1, 1'b0, '0, 1'b0);
    drainWords(2, 16'h0800, 1'b0);
    #2;
    applyReset();
    applyStimulus(1'b1, 1'b0, '0, 1'b0);
    drainWords(1, 16'h0900, 1'b0);
    applyStimulus(1'b0, 1'b0, '0, 1'b0);
    checkOutput("t6_row_restart", resIf.res_row, N_ROWS - 1);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, ($urandom_range(0, 1) == 1), W'($urandom), 1'b1);

    // Randomized traffic: occasional starts, bursty columns, flaky consumer.
    applyReset();
    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom_range(0, 7) == 0), ($urandom_range(0, 1) == 1),
                    W'($urandom), ($urandom_range(0, 2) != 0));
    end
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b0, '0, 1'b1);

`ifdef OS_DRAIN_TIMEOUT_EN
    // A drain that goes quiet is abandoned after TIMEOUT idle cycles.
    applyReset();
    applyStimulus(1'b1, 1'b0, '0, 1'b0);
    drainWords(2, 16'h0A00, 1'b0);
    for (int i = 0; i < TIMEOUT + 4; i++) applyStimulus(1'b0, 1'b0, '0, 1'b0);
    checkOutput("t7_timeout", timeoutErr, 1'b1);
    checkOutput("t7_busy", busy, 1'b0);
    checkOutput("t7_last0", resIf.res_last, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, '0, 1'b1);
`endif

    @(negedge clk);
    checkAll();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
